// File: rtl/calc_port_requester_if.sv
// Bundle of the command queue, calculator port and completion signals for one requester.
// master = requester side, slave = command source / calculator / completion sink side.
interface calc_port_requester_if #(
    parameter int INSTR_WD = 4,
    parameter int REG_WD   = 32,
    parameter int RSP_WD   = 2
);
    logic                req_valid;
    logic                req_ready;
    logic [INSTR_WD-1:0] req_op;
    logic [REG_WD-1:0]   req_op1;
    logic [REG_WD-1:0]   req_op2;
    logic [INSTR_WD-1:0] op;
    logic [REG_WD-1:0]   data_in;
    logic [1:0]          tag_in;
    logic [RSP_WD-1:0]   resp;
    logic [REG_WD-1:0]   data_out;
    logic [1:0]          tag_out;
    logic                cpl_valid;
    logic [RSP_WD-1:0]   cpl_resp;
    logic [REG_WD-1:0]   cpl_data;
    logic [1:0]          cpl_tag;
    logic [INSTR_WD-1:0] cpl_op;
    logic [2:0]          outstanding;
    logic                spurious_err;
    logic                cmd_err;

    modport master (
        input  req_valid, req_op, req_op1, req_op2, resp, data_out, tag_out,
        output req_ready, op, data_in, tag_in, cpl_valid, cpl_resp, cpl_data,
               cpl_tag, cpl_op, outstanding, spurious_err, cmd_err
    );

    modport slave (
        output req_valid, req_op, req_op1, req_op2, resp, data_out, tag_out,
        input  req_ready, op, data_in, tag_in, cpl_valid, cpl_resp, cpl_data,
               cpl_tag, cpl_op, outstanding, spurious_err, cmd_err
    );
endinterface

// File: rtl/calc_port_requester.sv
// Initiator for one calculator port: tag allocation, two-cycle command issue,
// and tag-matched completion reporting with the original op.
module calc_port_requester #(
    parameter int INSTR_WD = 4,
    parameter int REG_WD   = 32,
    parameter int RSP_WD   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    calc_port_requester_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2} state_t;

    state_t              state_q, state_d;
    logic [3:0]          busy_q, busy_d;
    logic [INSTR_WD-1:0] op_mem_q [4];
    logic [INSTR_WD-1:0] op_mem_d [4];
    logic [REG_WD-1:0]   op2_q, op2_d;
    logic [INSTR_WD-1:0] op_q, op_d;
    logic [REG_WD-1:0]   data_in_q, data_in_d;
    logic [1:0]          tag_in_q, tag_in_d;
    logic                cpl_valid_q, cpl_valid_d;
    logic [RSP_WD-1:0]   cpl_resp_q, cpl_resp_d;
    logic [REG_WD-1:0]   cpl_data_q, cpl_data_d;
    logic [1:0]          cpl_tag_q, cpl_tag_d;
    logic [INSTR_WD-1:0] cpl_op_q, cpl_op_d;
    logic                spur_q, spur_d;
    logic                cmd_err_q, cmd_err_d;

    logic [1:0] alloc_tag;
    logic       any_free;
    logic       ready;
    logic       accept;
    logic       accept_legal;

    // Lowest free tag, taken from the pre-edge busy vector only.
    always_comb begin
        alloc_tag = '0;
        any_free  = ~&busy_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!busy_q[3-i]) alloc_tag = 2'(3 - i);
        end
    end

    assign ready        = ((state_q == IDLE) || (state_q == ISSUE2)) && any_free;
    assign accept       = bus.req_valid && ready;
    assign accept_legal = accept && (bus.req_op != '0);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        op_mem_d    = op_mem_q;
        op2_d       = op2_q;
        op_d        = '0;
        data_in_d   = '0;
        tag_in_d    = '0;
        cpl_valid_d = 1'b0;
        cpl_resp_d  = cpl_resp_q;
        cpl_data_d  = cpl_data_q;
        cpl_tag_d   = cpl_tag_q;
        cpl_op_d    = cpl_op_q;
        spur_d      = spur_q;
        cmd_err_d   = cmd_err_q || (accept && (bus.req_op == '0));

        case (state_q)
            IDLE:    state_d = IDLE;
            ISSUE1:  state_d = ISSUE2;
            ISSUE2:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == ISSUE1) data_in_d = op2_q;

        if (accept_legal) begin
            state_d             = ISSUE1;
            busy_d[alloc_tag]   = 1'b1;
            op_mem_d[alloc_tag] = bus.req_op;
            op2_d               = bus.req_op2;
            op_d                = bus.req_op;
            data_in_d           = bus.req_op1;
            tag_in_d            = alloc_tag;
        end

        // A responding tag is busy pre-edge, so it can never equal alloc_tag.
        if (bus.resp != '0) begin
            if (busy_q[bus.tag_out]) begin
                busy_d[bus.tag_out] = 1'b0;
                cpl_valid_d         = 1'b1;
                cpl_resp_d          = bus.resp;
                cpl_data_d          = bus.data_out;
                cpl_tag_d           = bus.tag_out;
                cpl_op_d            = op_mem_q[bus.tag_out];
            end else begin
                spur_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= '0;
            op_mem_q    <= '{default: '0};
            op2_q       <= '0;
            op_q        <= '0;
            data_in_q   <= '0;
            tag_in_q    <= '0;
            cpl_valid_q <= 1'b0;
            cpl_resp_q  <= '0;
            cpl_data_q  <= '0;
            cpl_tag_q   <= '0;
            cpl_op_q    <= '0;
            spur_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            op_mem_q    <= op_mem_d;
            op2_q       <= op2_d;
            op_q        <= op_d;
            data_in_q   <= data_in_d;
            tag_in_q    <= tag_in_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_resp_q  <= cpl_resp_d;
            cpl_data_q  <= cpl_data_d;
            cpl_tag_q   <= cpl_tag_d;
            cpl_op_q    <= cpl_op_d;
            spur_q      <= spur_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.op           = op_q;
    assign bus.data_in      = data_in_q;
    assign bus.tag_in       = tag_in_q;
    assign bus.cpl_valid    = cpl_valid_q;
    assign bus.cpl_resp     = cpl_resp_q;
    assign bus.cpl_data     = cpl_data_q;
    assign bus.cpl_tag      = cpl_tag_q;
    assign bus.cpl_op       = cpl_op_q;
    assign bus.outstanding  = 3'(busy_q[0]) + 3'(busy_q[1]) + 3'(busy_q[2]) + 3'(busy_q[3]);
    assign bus.spurious_err = spur_q;
    assign bus.cmd_err      = cmd_err_q;
endmodule

// File: tb/tb_calc_port_requester.sv
// Scoreboard bench for calc_port_requester: directed scenarios followed by random traffic,
// with expectations from a tag-set / issue-slot reference model.
module tb_calc_port_requester;
    localparam int IW = 4;
    localparam int RW = 32;
    localparam int SW = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    calc_port_requester_if #(.INSTR_WD(IW), .REG_WD(RW), .RSP_WD(SW)) bus ();

    calc_port_requester #(.INSTR_WD(IW), .REG_WD(RW), .RSP_WD(SW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [IW-1:0] op;
        logic [RW-1:0] op1;
        logic [RW-1:0] op2;
        logic [1:0]    tag;
        int            due;
    } iss_t;

    typedef struct {
        logic [SW-1:0] resp;
        logic [RW-1:0] data;
        logic [1:0]    tag;
        logic [IW-1:0] op;
        int            due;
    } cpl_t;

    iss_t iss_q[$];
    cpl_t cpl_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: set of allocated tags with their ops, cycle of the last issued
    // command (the port needs two cycles per command), and the sticky error flags.
    bit            m_busy [4];
    logic [IW-1:0] m_op   [4];
    int            last_acc;
    bit            m_spur;
    bit            m_cmd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 1'b0;
            m_op[i]   = '0;
        end
        last_acc = -100;
        m_spur   = 1'b0;
        m_cmd    = 1'b0;
        iss_q.delete();
        cpl_q.delete();
    endtask

    // One clock cycle: check model-visible state, drive inputs, predict the next edge.
    task automatic step(input bit v, input logic [IW-1:0] op, input logic [RW-1:0] a,
                        input logic [RW-1:0] b, input logic [SW-1:0] rsp,
                        input logic [RW-1:0] dout, input logic [1:0] t, output bit acc);
        bit exp_rdy;
        int alloc;
        @(negedge clock);
        exp_rdy = (cyc - last_acc >= 2) && (m_count() < 4);
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("outstanding", bus.outstanding, m_count());
        chk("spurious_err", bus.spurious_err, m_spur);
        chk("cmd_err", bus.cmd_err, m_cmd);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_op1   = a;
        bus.req_op2   = b;
        bus.resp      = rsp;
        bus.data_out  = dout;
        bus.tag_out   = t;
        acc   = v && exp_rdy;
        alloc = 0;
        for (int i = 3; i >= 0; i--) if (!m_busy[i]) alloc = i;
        if (rsp != '0) begin
            if (m_busy[t]) begin
                cpl_q.push_back('{rsp, dout, t, m_op[t], cyc + 1});
                m_busy[t] = 1'b0;
            end else begin
                m_spur = 1'b1;
            end
        end
        if (acc) begin
            if (op == '0) begin
                m_cmd = 1'b1;
            end else begin
                m_busy[alloc] = 1'b1;
                m_op[alloc]   = op;
                last_acc      = cyc;
                iss_q.push_back('{op, a, b, 2'(alloc), cyc + 1});
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, '0, '0, acc);
    endtask

    task automatic send(input logic [IW-1:0] op, input logic [RW-1:0] a, input logic [RW-1:0] b);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 20) begin
            step(1, op, a, b, '0, '0, '0, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted (cycle %0d)", cyc);
        end
    endtask

    // Monitor: compares issue and completion traffic against the scoreboard queues.
    bit            mon_ph2 = 1'b0;
    logic [RW-1:0] mon_op2;
    iss_t          mon_e;
    cpl_t          mon_c;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                mon_ph2 = 1'b0;
                continue;
            end
            if (bus.cpl_valid) begin
                if (cpl_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cpl_unexpected actual=cpl_valid tag %0d expected=none (cycle %0d)",
                             bus.cpl_tag, cyc);
                end else begin
                    mon_c = cpl_q.pop_front();
                    chk("cpl_time", cyc, mon_c.due);
                    chk("cpl_resp", bus.cpl_resp, mon_c.resp);
                    chk("cpl_data", bus.cpl_data, mon_c.data);
                    chk("cpl_tag", bus.cpl_tag, mon_c.tag);
                    chk("cpl_op", bus.cpl_op, mon_c.op);
                end
            end
            if (cpl_q.size() > 0 && cpl_q[0].due < cyc) begin
                mon_c = cpl_q.pop_front();
                checks++;
                errors++;
                $display("FAIL cpl_missing actual=none expected=tag %0d due %0d (cycle %0d)",
                         mon_c.tag, mon_c.due, cyc);
            end
            if (mon_ph2) begin
                chk("issue2_op", bus.op, 0);
                chk("issue2_data", bus.data_in, mon_op2);
                chk("issue2_tag", bus.tag_in, 0);
                mon_ph2 = 1'b0;
            end else if (bus.op != '0) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected actual=op %0h expected=none (cycle %0d)",
                             bus.op, cyc);
                end else begin
                    mon_e = iss_q.pop_front();
                    chk("issue1_time", cyc, mon_e.due);
                    chk("issue1_op", bus.op, mon_e.op);
                    chk("issue1_data", bus.data_in, mon_e.op1);
                    chk("issue1_tag", bus.tag_in, mon_e.tag);
                    mon_op2 = mon_e.op2;
                    mon_ph2 = 1'b1;
                end
            end else begin
                chk("quiet_data_in", bus.data_in, 0);
                chk("quiet_tag_in", bus.tag_in, 0);
            end
            if (iss_q.size() > 0 && iss_q[0].due < cyc) begin
                mon_e = iss_q.pop_front();
                checks++;
                errors++;
                $display("FAIL issue_missing actual=none expected=op %0h due %0d (cycle %0d)",
                         mon_e.op, mon_e.due, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            acc;
        logic [RW-1:0] a, b;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.resp      = '0;
        bus.data_out  = '0;
        bus.tag_out   = '0;
        model_reset();

        repeat (2) @(negedge clock);
        chk("rst_op", bus.op, 0);
        chk("rst_data_in", bus.data_in, 0);
        chk("rst_tag_in", bus.tag_in, 0);
        chk("rst_cpl_valid", bus.cpl_valid, 0);
        chk("rst_cpl_data", bus.cpl_data, 0);
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_spurious", bus.spurious_err, 0);
        chk("rst_cmd_err", bus.cmd_err, 0);
        chk("rst_ready", bus.req_ready, 1);
        reset = 1'b0;

        // Single command, then its response during the ISSUE2 cycle.
        send(4'd1, 32'd5, 32'd7);
        idle(1);
        step(0, '0, '0, '0, 2'd1, 32'd12, 2'd0, acc);
        idle(3);

        // Five back-to-back commands; the fifth stalls until tag 2 returns.
        for (int k = 0; k < 4; k++) send(4'(k + 1), $urandom, $urandom);
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 4; i++) step(1, 4'd5, a, b, '0, '0, '0, acc);
        step(1, 4'd5, a, b, 2'd1, 32'hCAFE0002, 2'd2, acc);
        send(4'd5, a, b);
        idle(3);

        // Out-of-order responses.
        step(0, '0, '0, '0, 2'd1, 32'hA3, 2'd3, acc);
        step(0, '0, '0, '0, 2'd2, 32'hA0, 2'd0, acc);
        step(0, '0, '0, '0, 2'd3, 32'hA2, 2'd2, acc);
        step(0, '0, '0, '0, 2'd1, 32'hA1, 2'd1, acc);
        idle(2);

        // Response for a free tag.
        step(0, '0, '0, '0, 2'd2, 32'hDEAD, 2'd1, acc);
        idle(3);

        // Reset in the ISSUE1 cycle; the abandoned tag's later response is spurious.
        send(4'd9, 32'h11, 32'h22);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("midrst_op", bus.op, 0);
        chk("midrst_data_in", bus.data_in, 0);
        chk("midrst_tag_in", bus.tag_in, 0);
        chk("midrst_outstanding", bus.outstanding, 0);
        chk("midrst_spurious", bus.spurious_err, 0);
        model_reset();
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        chk("postrst_ready", bus.req_ready, 1);
        step(0, '0, '0, '0, 2'd1, 32'h33, 2'd0, acc);
        idle(2);

        // Random traffic, including illegal ops and stray responses.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom,
                 2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)), acc);
        end
        bus.req_valid = 1'b0;
        for (int t = 0; t < 4; t++) step(0, '0, '0, '0, 2'd1, $urandom, 2'(t), acc);
        idle(4);
        chk("issue_queue_drained", iss_q.size(), 0);
        chk("cpl_queue_drained", cpl_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
